load_align_writeback: RTL

// - Parametrised load-return unit between data memory and the register-file write port.
// - Accepts one load per handshake and issues one or two aligned dmem reads.
//   Two reads occur when the access crosses an XLEN word boundary.
// - Merges the two words, extracts and sign/zero-extends the loaded bytes, and presents the

---
 rtl/load_align_writeback_pkg.sv | 42 ++++
 rtl/load_align_writeback_if.sv | 42 ++++
 rtl/load_align_writeback_extract.sv | 35 +++
 rtl/load_align_writeback.sv | 122 ++++++++++++
 4 files changed

// File: rtl/load_align_writeback_pkg.sv
// Shared types for the load-return unit: sizes, FSM states, request bundle.
// Also holds the funct3 legality and size helpers used by the FSM.
package load_align_writeback_pkg;

  localparam int ADDR_MAX = 64;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } load_size_e;

  typedef enum logic [1:0] {
    IDLE,
    RD0,
    RD1,
    RESP
  } lau_state_e;

  typedef struct packed {
    logic [ADDR_MAX-1:0] addr;
    logic [2:0]          funct3;
    logic [4:0]          rd;
  } lau_req_t;

  function automatic logic illegal_funct3(
    input logic [2:0] f3,
    input logic       wide
  );
    if (wide)
      return f3 == 3'b111;
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic [3:0] size_bytes(
    input load_size_e sz
  );
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/load_align_writeback_if.sv
// Request, data-memory and writeback signals of the load-return unit.
// slave is the unit's view, master is the surrounding pipeline/memory.
interface load_align_writeback_if #(
  parameter int XLEN = 32
);

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic [2:0]      req_funct3;
  logic [4:0]      req_rd;

  logic            dmem_read;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_resp;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic [4:0]      rsp_rd;
  logic            rsp_fault;

  modport slave (
    input  req_valid, req_addr, req_funct3, req_rd,
    output req_ready,
    output dmem_read, dmem_addr,
    input  dmem_rdata, dmem_resp,
    output rsp_valid, rsp_data, rsp_rd, rsp_fault,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_addr, req_funct3, req_rd,
    input  req_ready,
    input  dmem_read, dmem_addr,
    output dmem_rdata, dmem_resp,
    input  rsp_valid, rsp_data, rsp_rd, rsp_fault,
    output rsp_ready
  );

endinterface

// File: rtl/load_align_writeback_extract.sv
// Merges the two dmem words, shifts the addressed bytes down
// and sign/zero-extends them to XLEN.
module load_extract
  import load_align_writeback_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]              word0,
  input  logic [XLEN-1:0]              word1,
  input  logic [$clog2(XLEN/8)-1:0]    off,
  input  logic [2:0]                   funct3,
  output logic [XLEN-1:0]              data
);

  localparam int IW = $clog2(XLEN);

  load_size_e      sz;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] hi_mask;
  logic [6:0]      nbits;
  logic [IW-1:0]   sidx;
  logic            fill;

  // A full-width load shifts the mask out entirely, leaving no fill.
  always_comb begin
    sz      = load_size_e'(funct3[1:0]);
    lo      = XLEN'({word1, word0} >> {off, 3'b000});
    nbits   = 7'd8 << sz;
    hi_mask = {XLEN{1'b1}} << nbits;
    sidx    = IW'(nbits - 7'd1);
    fill    = ~funct3[2] & lo[sidx];
    data    = (lo & ~hi_mask) | (fill ? hi_mask : '0);
  end

endmodule

// File: rtl/load_align_writeback.sv
// Load-return unit: one or two aligned dmem reads per load,
// then merge/extend and hand the result to the register-file write port.
module load_align_writeback
  import load_align_writeback_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  load_align_writeback_if.slave bus
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(NB - 1);

  lau_state_e      state;
  lau_state_e      state_nx;
  lau_req_t        req;
  logic [XLEN-1:0] word0;
  logic [XLEN-1:0] word1;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] result;
  logic            fault;
  logic            in_split;
  logic            in_bad;
  logic            req_split;

  // Extra top bit keeps off+size from wrapping at the word edge.
  function automatic logic crosses(
    input logic [OFFW-1:0] off,
    input logic [2:0]      f3
  );
    return ({1'b0, 4'(off)} +
            {1'b0, size_bytes(load_size_e'(f3[1:0]))}) > 5'(NB);
  endfunction

  assign in_split  = crosses(bus.req_addr[OFFW-1:0], bus.req_funct3);
  assign in_bad    = illegal_funct3(bus.req_funct3, XLEN == 64) ||
                     (in_split && !ALLOW_MISALIGN);
  assign req_split = crosses(req.addr[OFFW-1:0], req.funct3);
  assign base      = req.addr[XLEN-1:0] & ALIGN;

  load_extract #(
    .XLEN (XLEN)
  ) u_extract (
    .word0  (word0),
    .word1  (word1),
    .off    (req.addr[OFFW-1:0]),
    .funct3 (req.funct3),
    .data   (result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.dmem_read = 1'b0;
    bus.dmem_addr = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    bus.rsp_rd    = '0;
    bus.rsp_fault = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid)
          state_nx = in_bad ? RESP : RD0;
      end
      RD0: begin
        bus.dmem_read = 1'b1;
        bus.dmem_addr = base;
        if (bus.dmem_resp)
          state_nx = req_split ? RD1 : RESP;
      end
      RD1: begin
        bus.dmem_read = 1'b1;
        bus.dmem_addr = base + XLEN'(NB);
        if (bus.dmem_resp)
          state_nx = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = fault ? '0 : result;
        bus.rsp_rd    = req.rd;
        bus.rsp_fault = fault;
        if (bus.rsp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req   <= '0;
      word0 <= '0;
      word1 <= '0;
      fault <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        req.addr   <= ADDR_MAX'(bus.req_addr);
        req.funct3 <= bus.req_funct3;
        req.rd     <= bus.req_rd;
        fault      <= in_bad;
        word1      <= '0;
      end
      if (state == RD0 && bus.dmem_resp)
        word0 <= bus.dmem_rdata;
      if (state == RD1 && bus.dmem_resp)
        word1 <= bus.dmem_rdata;
    end
  end

endmodule
